// File: rtl/counter_sequencer.sv
// counter_sequencer: run-controller that clears, counts and holds an up_counter at a programmed terminal value
module counter_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] terminal,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic             busy,
    output logic             done,
    output logic [7:0]       reload_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] term_q;
    logic             reload_q;
    // Run FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt_enable <= 1'b0;
            cnt_clear  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            reload_cnt <= 8'd0;
            term_q     <= '0;
            reload_q   <= 1'b0;
        end else begin
            done      <= 1'b0;
            cnt_clear <= 1'b0;
            if (stop && state != IDLE) begin
                state      <= IDLE;
                cnt_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !stop) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        term_q     <= terminal;
                        reload_q   <= auto_reload;
                        reload_cnt <= 8'd0;
                        cnt_clear  <= 1'b1;
                    end
                    CLEAR: if (term_q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= RUN;
                        cnt_enable <= 1'b1;
                    end
                    // Terminal check uses T-1: the counter takes its last increment on the edge we stop enabling
                    RUN: if (cnt_enable && cnt_value == term_q - WIDTH'(1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        cnt_enable <= 1'b0;
                    end else if (pause) begin
                        state      <= PAUSE;
                        cnt_enable <= 1'b0;
                    end
                    PAUSE: if (!pause) begin
                        state      <= RUN;
                        cnt_enable <= 1'b1;
                    end
                    DONE: if (reload_q) begin
                        state      <= CLEAR;
                        cnt_clear  <= 1'b1;
                        reload_cnt <= reload_cnt + 8'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed checks of counter_sequencer driving a behavioural up_counter
module tb_counter_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] terminal = 8'd0;
    logic [7:0] cnt_value = 8'd0;
    logic       cnt_enable;
    logic       cnt_clear;
    logic       busy;
    logic       done;
    logic [7:0] reload_cnt;
    int         passed = 0;
    int         total = 0;

    counter_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .terminal(terminal), .cnt_value(cnt_value),
        .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .busy(busy), .done(done),
        .reload_cnt(reload_cnt)
    );

    always #5 clk = ~clk;

    // Controlled up_counter: sync active-high clear beats enable, +1 per enabled edge, wraps
    always_ff @(posedge clk) begin
        if (cnt_clear) cnt_value <= 8'd0;
        else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start so it is sampled on the next edge (edge 0 of the run)
    task automatic launch(input int t, input logic ar);
        terminal = 8'(t);
        auto_reload = ar;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({cnt_enable, cnt_clear, busy, done} !== 4'b0100) $display("FAIL reset_ctrl got en/clr/busy/done=%b want 0100", {cnt_enable, cnt_clear, busy, done});
        else passed++;
        total++;
        if (reload_cnt !== 8'd0 || cnt_value !== 8'd0) $display("FAIL reset_vals got reload_cnt=%0d cnt_value=%0d want 0 0", reload_cnt, cnt_value);
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if (cnt_clear !== 1'b0) $display("FAIL reset_release got cnt_clear=%b want 0", cnt_clear);
        else passed++;
    endtask

    task automatic test_one_shot(input int t);
        int ev;
        launch(t, 1'b0);
        total++;
        if (busy !== 1'b1 || cnt_clear !== 1'b1) $display("FAIL start_T%0d got busy=%b clr=%b want 1 1", t, busy, cnt_clear);
        else passed++;
        for (int n = 1; n <= t + 4; n++) begin
            tick();
            ev = (n - 1 > t) ? t : n - 1;
            total++;
            if (cnt_value !== 8'(ev)) $display("FAIL value_T%0d edge %0d got %0d want %0d", t, n, cnt_value, ev);
            else passed++;
            total++;
            if (done !== (n == t + 1)) $display("FAIL done_T%0d edge %0d got %b want %b", t, n, done, n == t + 1);
            else passed++;
            total++;
            if (busy !== (n <= t + 1)) $display("FAIL busy_T%0d edge %0d got %b want %b", t, n, busy, n <= t + 1);
            else passed++;
        end
    endtask

    task automatic test_pause;
        int ev;
        launch(6, 1'b0);
        for (int n = 1; n <= 13; n++) begin
            tick();
            ev = (n <= 4) ? n - 1 : (n <= 7) ? 3 : ((n - 4 > 6) ? 6 : n - 4);
            total++;
            if (cnt_value !== 8'(ev)) $display("FAIL pause_value edge %0d got %0d want %0d", n, cnt_value, ev);
            else passed++;
            total++;
            if (done !== (n == 10)) $display("FAIL pause_done edge %0d got %b want %b", n, done, n == 10);
            else passed++;
            if (n == 5) begin
                total++;
                if (cnt_enable !== 1'b0) $display("FAIL pause_enable got %b want 0", cnt_enable);
                else passed++;
            end
            pause = (n >= 3 && n <= 5);
        end
        launch(6, 1'b0);
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 7) begin
                total++;
                if (done !== 1'b1 || cnt_value !== 8'd6) $display("FAIL pause_at_T-1 got done=%b value=%0d want 1 6", done, cnt_value);
                else passed++;
            end
            if (n == 6) pause = 1'b1;
        end
        pause = 1'b0;
    endtask

    task automatic test_auto_reload;
        launch(3, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            tick();
            total++;
            if (done !== (n >= 4 && (n - 4) % 5 == 0)) $display("FAIL reload_done edge %0d got %b", n, done);
            else passed++;
            if (done === 1'b1) begin
                total++;
                if (cnt_value !== 8'd3) $display("FAIL reload_value edge %0d got %0d want 3", n, cnt_value);
                else passed++;
            end
            if (n % 5 == 0) begin
                total++;
                if (reload_cnt !== 8'(n / 5)) $display("FAIL reload_cnt edge %0d got %0d want %0d", n, reload_cnt, n / 5);
                else passed++;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || cnt_enable !== 1'b0) $display("FAIL stop got busy=%b en=%b want 0 0", busy, cnt_enable);
        else passed++;
        for (int n = 0; n < 10; n++) begin
            tick();
            total++;
            if (done !== 1'b0 || cnt_enable !== 1'b0 || busy !== 1'b0) $display("FAIL after_stop cycle %0d got done=%b en=%b busy=%b want 0 0 0", n, done, cnt_enable, busy);
            else passed++;
        end
    endtask

    task automatic test_start_conflicts;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || cnt_clear !== 1'b0) $display("FAIL start_stop_idle got busy=%b clr=%b want 0 0", busy, cnt_clear);
        else passed++;
        launch(5, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            tick();
            start = (n == 3);
            terminal = (n == 3) ? 8'd2 : 8'd5;
            total++;
            if (done !== (n == 6)) $display("FAIL busy_start_done edge %0d got %b want %b", n, done, n == 6);
            else passed++;
            if (n == 6) begin
                total++;
                if (cnt_value !== 8'd5) $display("FAIL busy_start_value got %0d want 5", cnt_value);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_run;
        launch(10, 1'b0);
        for (int n = 1; n <= 5; n++) tick();
        total++;
        if (cnt_value !== 8'd4) $display("FAIL midrun_setup got %0d want 4", cnt_value);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if ({cnt_enable, cnt_clear, busy, done} !== 4'b0100) $display("FAIL midrun_reset got en/clr/busy/done=%b want 0100", {cnt_enable, cnt_clear, busy, done});
        else passed++;
        tick();
        total++;
        if (cnt_value !== 8'd0) $display("FAIL midrun_cleared got %0d want 0", cnt_value);
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if (cnt_clear !== 1'b0 || busy !== 1'b0) $display("FAIL midrun_release got clr=%b busy=%b want 0 0", cnt_clear, busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_one_shot(5);
        test_one_shot(0);
        test_one_shot(255);
        test_pause();
        test_auto_reload();
        test_start_conflicts();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
